// File: rtl/crc_par_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_par_engine_pkg
// Description : Shared types and the single-bit LFSR step used by the
//               parallel CRC engine.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_par_engine_pkg;

  // Widest CRC the step function handles; callers zero-extend into this width.
  localparam int CRC_MAX_WD = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SHIFT = 2'd2
  } crc_state_e;

  // One LFSR step for data bit d on a wd-bit register held in the low bits of r.
  // Feedback enters the MSB; taps apply only below the MSB.
  function automatic logic [CRC_MAX_WD-1:0] crc_step(
    input logic [CRC_MAX_WD-1:0] r,
    input logic                  d,
    input logic [CRC_MAX_WD-1:0] taps,
    input int unsigned           wd
  );
    logic                  fb;
    logic [CRC_MAX_WD-1:0] lo_mask;
    logic [CRC_MAX_WD-1:0] nxt;
    fb      = d ^ r[0];
    lo_mask = (CRC_MAX_WD'(1) << (wd - 1)) - CRC_MAX_WD'(1);
    nxt     = (r >> 1) ^ (taps & lo_mask & {CRC_MAX_WD{fb}});
    nxt     = nxt | (CRC_MAX_WD'(fb) << (wd - 1));
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_par_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_par_engine_if
// Description : Frame-in / CRC-out bus of the parallel CRC engine.
//               Optional CRC_CHECK_EN adds the expected-CRC compare signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface crc_par_engine_if #(
  parameter int CRC_WD = 8,
  parameter int IN_WD  = 1,
  parameter int OUT_WD = 1
);
  logic              active;
  logic [IN_WD-1:0]  data;
  logic [OUT_WD-1:0] crc;
  logic              valid;
  logic              busy;
  logic              overrun;

  // The CRC must split into whole output beats.
  if ((CRC_WD % OUT_WD) != 0 || IN_WD < 1) begin : g_bad_cfg
    $error("crc_par_engine_if: CRC_WD must be a multiple of OUT_WD and IN_WD >= 1");
  end

`ifdef CRC_CHECK_EN
  logic [CRC_WD-1:0] crc_exp;
  logic              match;
  logic              match_vld;

  modport master (output active, output data, output crc_exp,
                  input crc, input valid, input busy, input overrun,
                  input match, input match_vld);
  modport slave  (input active, input data, input crc_exp,
                  output crc, output valid, output busy, output overrun,
                  output match, output match_vld);
`else
  modport master (output active, output data,
                  input crc, input valid, input busy, input overrun);
  modport slave  (input active, input data,
                  output crc, output valid, output busy, output overrun);
`endif

endinterface
`default_nettype wire

// File: rtl/crc_par_engine_serializer.sv
`default_nettype none
// ============================================================================
// Module      : crc_par_engine_serializer
// Description : Streams a loaded CRC out OUT_WD bits per beat, LSB first,
//               with Valid/BUSY framing and a last-beat indication.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_par_engine_serializer #(
  parameter int CRC_WD = 8,
  parameter int OUT_WD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [CRC_WD-1:0] i_value,
  output logic [OUT_WD-1:0] o_crc,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_last
);
  localparam int BEATS  = CRC_WD / OUT_WD;
  localparam int CNT_WD = $clog2(BEATS + 1);
  localparam logic [CNT_WD-1:0] c_beats = CNT_WD'(BEATS);
  localparam logic [CNT_WD-1:0] c_one   = CNT_WD'(1);

  logic [CRC_WD-1:0] r_shreg;
  logic [CNT_WD-1:0] r_cnt;
  logic [OUT_WD-1:0] r_crc;
  logic              r_valid;
  logic              r_busy;

  // The beat currently on the output is the final one.
  assign o_last = r_busy && (r_cnt == c_beats);

  // Load presents beat 1 immediately; each following edge advances one slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_crc   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      r_crc   <= i_value[OUT_WD-1:0];
      r_shreg <= i_value >> OUT_WD;
      r_cnt   <= c_one;
      r_valid <= 1'b1;
      r_busy  <= 1'b1;
    end else if (o_last) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_crc   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_crc   <= r_shreg[OUT_WD-1:0];
      r_shreg <= r_shreg >> OUT_WD;
      r_cnt   <= r_cnt + c_one;
    end
  end

  assign o_crc   = r_crc;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: rtl/crc_par_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_par_engine
// Description : Parametrised LFSR CRC generator. Absorbs IN_WD data bits per
//               ACTIVE cycle, then streams the CRC out OUT_WD bits per beat.
//               Define CRC_CHECK_EN to add the expected-CRC comparator
//               (crc_exp in, match / match_vld out).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_par_engine
  import crc_par_engine_pkg::*;
#(
  parameter int                CRC_WD = 8,
  parameter int                IN_WD  = 1,
  parameter int                OUT_WD = 1,
  parameter logic [CRC_WD-1:0] SEED   = 8'hD8,
  parameter logic [CRC_WD-1:0] TAPS   = 8'h44
) (
  input  logic            clk,
  input  logic            rst_n,
  crc_par_engine_if.slave bus
);

  if ((CRC_WD % OUT_WD) != 0 || IN_WD < 1 || CRC_WD > CRC_MAX_WD) begin : g_bad_cfg
    $error("crc_par_engine: illegal CRC_WD/IN_WD/OUT_WD combination");
  end

  crc_state_e        r_state;
  logic [CRC_WD-1:0] r_lfsr;
  logic [CRC_WD-1:0] w_lfsr_nxt;
  logic              r_overrun;
  logic              w_load;
  logic              w_last;

  // IN_WD LFSR steps chained in one cycle, DATA[0] applied first.
  always_comb begin
    w_lfsr_nxt = (r_state == ST_IDLE) ? SEED : r_lfsr;
    for (int k = 0; k < IN_WD; k++) begin
      w_lfsr_nxt = CRC_WD'(crc_step(CRC_MAX_WD'(w_lfsr_nxt), bus.data[k],
                                    CRC_MAX_WD'(TAPS), CRC_WD));
    end
  end

  // Frame end: first edge that sees ACTIVE low while calculating.
  assign w_load = (r_state == ST_CALC) && !bus.active;

  // Frame FSM; the LFSR holds the final CRC untouched for the whole shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lfsr    <= SEED;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_state == ST_SHIFT) && bus.active;
      case (r_state)
        ST_IDLE: begin
          if (bus.active) begin
            r_lfsr  <= w_lfsr_nxt;
            r_state <= ST_CALC;
          end else begin
            r_lfsr  <= SEED;
          end
        end
        ST_CALC: begin
          if (bus.active) r_lfsr  <= w_lfsr_nxt;
          else            r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_lfsr  <= SEED;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_lfsr  <= SEED;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  crc_par_engine_serializer #(
    .CRC_WD (CRC_WD),
    .OUT_WD (OUT_WD)
  ) u_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (r_lfsr),
    .o_crc   (bus.crc),
    .o_valid (bus.valid),
    .o_busy  (bus.busy),
    .o_last  (w_last)
  );

  assign bus.overrun = r_overrun;

`ifdef CRC_CHECK_EN
  logic [CRC_WD-1:0] r_crc_exp;
  logic              r_match;
  logic              r_match_vld;

  // Capture the expected CRC at frame end; compare when shift-out completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_exp   <= '0;
      r_match     <= 1'b0;
      r_match_vld <= 1'b0;
    end else begin
      r_match_vld <= 1'b0;
      if (w_load) r_crc_exp <= bus.crc_exp;
      if ((r_state == ST_SHIFT) && w_last) begin
        r_match_vld <= 1'b1;
        r_match     <= (r_lfsr == r_crc_exp);
      end
    end
  end

  assign bus.match     = r_match;
  assign bus.match_vld = r_match_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_par_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_par_engine
// Description : Self-checking bench for crc_par_engine: three configurations
//               (IN/OUT = 1/1, 8/4, 3/2) against a bit-serial CRC model.
//               CRC_CHECK_EN adds the comparator scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_par_engine;

  localparam logic [7:0] SEED = 8'hD8;
  localparam logic [7:0] TAPS = 8'h44;
  localparam int         NCAP = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc_par_engine_if #(.CRC_WD(8), .IN_WD(1), .OUT_WD(1)) if_a ();
  crc_par_engine_if #(.CRC_WD(8), .IN_WD(8), .OUT_WD(4)) if_b ();
  crc_par_engine_if #(.CRC_WD(8), .IN_WD(3), .OUT_WD(2)) if_c ();

  crc_par_engine #(.CRC_WD(8), .IN_WD(1), .OUT_WD(1), .SEED(SEED), .TAPS(TAPS))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  crc_par_engine #(.CRC_WD(8), .IN_WD(8), .OUT_WD(4), .SEED(SEED), .TAPS(TAPS))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  crc_par_engine #(.CRC_WD(8), .IN_WD(3), .OUT_WD(2), .SEED(SEED), .TAPS(TAPS))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] m_a, m_b, m_c;
  bit         va[NCAP], vb[NCAP], vc[NCAP];
  bit         ba[NCAP], bb[NCAP], bc[NCAP];
  bit         oa[NCAP];
  logic [7:0] ca[NCAP], cb[NCAP], cc[NCAP];

  // Bit-serial CRC reference: reflected polynomial division, one bit at a time.
  function automatic logic [7:0] ref_feed(input logic [7:0] r, input logic [31:0] d, input int nbits);
    int unsigned s;
    int unsigned poly;
    poly = 32'h80 | (32'(TAPS) & 32'h7F);
    s    = 32'(r);
    for (int k = 0; k < nbits; k++) begin
      s = s ^ ((d >> k) & 32'd1);
      if (s % 2 == 1) s = (s / 2) ^ poly;
      else            s = s / 2;
    end
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame of len ACTIVE cycles on the enabled engines, then the terminating edge.
  task automatic drive_frame(input int len, input bit en_a, input bit en_b, input bit en_c, input bit rnd);
    logic [31:0] dr;
    m_a = SEED; m_b = SEED; m_c = SEED;
    for (int cyc = 0; cyc < len; cyc++) begin
      dr = rnd ? 32'($urandom) : 32'd0;
      if (en_a) begin if_a.active = 1'b1; if_a.data = dr[0];     m_a = ref_feed(m_a, dr, 1);       end
      if (en_b) begin if_b.active = 1'b1; if_b.data = dr[15:8];  m_b = ref_feed(m_b, dr >> 8, 8);  end
      if (en_c) begin if_c.active = 1'b1; if_c.data = dr[26:24]; m_c = ref_feed(m_c, dr >> 24, 3); end
      tick();
    end
    if_a.active = 1'b0; if_a.data = '0;
    if_b.active = 1'b0; if_b.data = '0;
    if_c.active = 1'b0; if_c.data = '0;
    tick();
  endtask

  // Record NCAP cycles of outputs; optionally pulse engine A's ACTIVE at cycle ovr_at.
  task automatic capture(input int ovr_at);
    for (int i = 0; i < NCAP; i++) begin
      va[i] = if_a.valid; ba[i] = if_a.busy; ca[i] = {7'b0, if_a.crc}; oa[i] = if_a.overrun;
      vb[i] = if_b.valid; bb[i] = if_b.busy; cb[i] = {4'b0, if_b.crc};
      vc[i] = if_c.valid; bc[i] = if_c.busy; cc[i] = {6'b0, if_c.crc};
      if (i == ovr_at) begin
        if_a.active = 1'b1;
        if_a.data   = 1'($urandom);
      end else if (i == ovr_at + 1) begin
        if_a.active = 1'b0;
      end
      tick();
    end
  endtask

  // Reassemble beats LSB first and judge the Valid/BUSY envelope.
  task automatic decode(input bit v[NCAP], input bit b[NCAP], input logic [7:0] c[NCAP],
                        input int ow, output logic [7:0] got, output bit shape);
    int         beats;
    logic [7:0] mask;
    beats = 8 / ow;
    mask  = 8'((1 << ow) - 1);
    got   = 8'h00;
    shape = 1'b1;
    for (int i = 0; i < NCAP; i++) begin
      if (v[i] != (i < beats) || b[i] != v[i]) shape = 1'b0;
      if (i < beats) got = got | ((c[i] & mask) << (i * ow));
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_chk++; if (if_a.valid !== 1'b0)   $display("FAIL reset_valid: got %b want 0", if_a.valid);   else n_pass++;
    n_chk++; if (if_a.busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", if_a.busy);     else n_pass++;
    n_chk++; if (if_a.crc !== 1'b0)     $display("FAIL reset_crc: got %b want 0", if_a.crc);       else n_pass++;
    n_chk++; if (if_a.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", if_a.overrun); else n_pass++;
    n_chk++; if (if_b.crc !== 4'h0)     $display("FAIL reset_crc_b: got %h want 0", if_b.crc);     else n_pass++;
    n_chk++; if (if_c.busy !== 1'b0)    $display("FAIL reset_busy_c: got %b want 0", if_c.busy);   else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_serial_zero();
    logic [7:0] got;
    bit         shape;
    int         n_ov;
    drive_frame(8, 1, 0, 0, 0);
    capture(-1);
    decode(va, ba, ca, 1, got, shape);
    n_ov = 0;
    for (int i = 0; i < NCAP; i++) n_ov += int'(oa[i]);
    n_chk++; if (got !== 8'h14)  $display("FAIL zero_frame_crc: got %h want 14", got);           else n_pass++;
    n_chk++; if (got !== m_a)    $display("FAIL zero_frame_model: got %h want %h", got, m_a);    else n_pass++;
    n_chk++; if (shape !== 1'b1) $display("FAIL zero_frame_valid_shape: got %b want 1", shape);  else n_pass++;
    n_chk++; if (n_ov !== 0)     $display("FAIL zero_frame_overrun: got %0d want 0", n_ov);      else n_pass++;
  endtask

  task automatic test_wide_single();
    logic [7:0] got;
    bit         shape;
    drive_frame(1, 0, 1, 0, 0);
    capture(-1);
    decode(vb, bb, cb, 4, got, shape);
    n_chk++; if (cb[0] !== 8'h04) $display("FAIL wide_beat0: got %h want 4", cb[0]);          else n_pass++;
    n_chk++; if (cb[1] !== 8'h01) $display("FAIL wide_beat1: got %h want 1", cb[1]);          else n_pass++;
    n_chk++; if (shape !== 1'b1)  $display("FAIL wide_valid_shape: got %b want 1", shape);    else n_pass++;
    n_chk++; if (got !== m_b)     $display("FAIL wide_model: got %h want %h", got, m_b);      else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    bit         shape;
    int         n_ov;
    drive_frame(8, 1, 0, 0, 0);
    capture(2);
    decode(va, ba, ca, 1, got, shape);
    n_ov = 0;
    for (int i = 0; i < NCAP; i++) n_ov += int'(oa[i]);
    n_chk++; if (got !== 8'h14)  $display("FAIL overrun_crc: got %h want 14", got);          else n_pass++;
    n_chk++; if (shape !== 1'b1) $display("FAIL overrun_valid_shape: got %b want 1", shape); else n_pass++;
    n_chk++; if (oa[3] !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", oa[3]);      else n_pass++;
    n_chk++; if (n_ov !== 1)     $display("FAIL overrun_count: got %0d want 1", n_ov);       else n_pass++;
    drive_frame(8, 1, 0, 0, 0);
    capture(-1);
    decode(va, ba, ca, 1, got, shape);
    n_chk++; if (got !== 8'h14)  $display("FAIL after_overrun_crc: got %h want 14", got);    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] got;
    bit         shape;
    drive_frame(8, 1, 0, 0, 0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if (if_a.valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", if_a.valid); else n_pass++;
    n_chk++; if (if_a.busy !== 1'b0)  $display("FAIL midreset_busy: got %b want 0", if_a.busy);   else n_pass++;
    n_chk++; if (if_a.crc !== 1'b0)   $display("FAIL midreset_crc: got %b want 0", if_a.crc);     else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (if_a.valid !== 1'b0) $display("FAIL postreset_valid: got %b want 0", if_a.valid); else n_pass++;
    drive_frame(8, 1, 0, 0, 0);
    capture(-1);
    decode(va, ba, ca, 1, got, shape);
    n_chk++; if (got !== 8'h14)  $display("FAIL postreset_crc: got %h want 14", got);         else n_pass++;
    n_chk++; if (shape !== 1'b1) $display("FAIL postreset_shape: got %b want 1", shape);     else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] got;
    bit         shape;
    int         len;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 64));
      drive_frame(len, 1, 1, 1, 1);
      capture(-1);
      decode(va, ba, ca, 1, got, shape);
      n_chk++; if (got !== m_a)    $display("FAIL rand_a_crc f%0d len%0d: got %h want %h", f, len, got, m_a); else n_pass++;
      n_chk++; if (shape !== 1'b1) $display("FAIL rand_a_shape f%0d: got %b want 1", f, shape);               else n_pass++;
      decode(vb, bb, cb, 4, got, shape);
      n_chk++; if (got !== m_b)    $display("FAIL rand_b_crc f%0d len%0d: got %h want %h", f, len, got, m_b); else n_pass++;
      n_chk++; if (shape !== 1'b1) $display("FAIL rand_b_shape f%0d: got %b want 1", f, shape);               else n_pass++;
      decode(vc, bc, cc, 2, got, shape);
      n_chk++; if (got !== m_c)    $display("FAIL rand_c_crc f%0d len%0d: got %h want %h", f, len, got, m_c); else n_pass++;
      n_chk++; if (shape !== 1'b1) $display("FAIL rand_c_shape f%0d: got %b want 1", f, shape);               else n_pass++;
    end
  endtask

`ifdef CRC_CHECK_EN
  int mv_cnt = 0;
  always @(negedge clk) if (if_a.match_vld === 1'b1) mv_cnt++;

  task automatic test_check();
    int mv0;
    if_a.crc_exp = 8'h14;
    mv0 = mv_cnt;
    drive_frame(8, 1, 0, 0, 0);
    capture(-1);
    n_chk++; if (mv_cnt - mv0 !== 1)   $display("FAIL check_pulse: got %0d want 1", mv_cnt - mv0); else n_pass++;
    n_chk++; if (if_a.match !== 1'b1)  $display("FAIL check_match: got %b want 1", if_a.match);   else n_pass++;
    if_a.crc_exp = 8'h15;
    drive_frame(8, 1, 0, 0, 0);
    capture(-1);
    n_chk++; if (if_a.match !== 1'b0)  $display("FAIL check_nomatch: got %b want 0", if_a.match); else n_pass++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_a.active = 1'b0; if_a.data = '0;
    if_b.active = 1'b0; if_b.data = '0;
    if_c.active = 1'b0; if_c.data = '0;
`ifdef CRC_CHECK_EN
    if_a.crc_exp = '0; if_b.crc_exp = '0; if_c.crc_exp = '0;
`endif
    test_reset();
    test_serial_zero();
    test_wide_single();
    test_overrun();
    test_reset_mid_shift();
`ifdef CRC_CHECK_EN
    test_check();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
